// File: rtl/mem_bus_ctrl_if.sv
// Request/response bus between an upstream processor and mem_bus_ctrl.
// The master drives request strobes; the slave answers with read data, status and busy.
interface mem_bus_ctrl_if;
    logic        read_en;
    logic        write_en;
    logic [15:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_valid;
    logic        error;
    logic        busy;

    modport master (
        output read_en, write_en, address, write_data,
        input  read_data, read_valid, error, busy
    );

    modport slave (
        input  read_en, write_en, address, write_data,
        output read_data, read_valid, error, busy
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding memory bus controller: 256x32 RAM plus ID/SCRATCH/WR_CNT/ERR_CNT registers.
// Writes complete one edge after acceptance, reads two edges after acceptance.
module mem_bus_ctrl (
    input  logic           clk,
    input  logic           reset,
    mem_bus_ctrl_if.slave  bus
);
    localparam logic [31:0] ID_VALUE = 32'hC0DE0003;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        both_q, both_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [31:0] read_data_q, read_data_d;
    logic        read_valid_q, read_valid_d;
    logic        error_q, error_d;
    logic [31:0] mem_q [256];

    logic        mem_we;
    logic        wr_inc;
    logic [1:0]  err_inc;
    logic        req;
    logic        aligned;
    logic        hit_ram;
    logic        hit_periph;

    assign req        = bus.read_en | bus.write_en;
    assign aligned    = (addr_q[1:0] == 2'b00);
    assign hit_ram    = aligned && (addr_q[15:10] == 6'd0);
    assign hit_periph = aligned && (addr_q[15:4] == 12'h800);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        both_d       = both_q;
        scratch_d    = scratch_q;
        read_data_d  = 32'd0;
        read_valid_d = 1'b0;
        error_d      = 1'b0;
        mem_we       = 1'b0;
        wr_inc       = 1'b0;
        err_inc      = 2'd0;

        // A request while not idle is dropped; it can coincide with a completion error.
        if (req && state_q != IDLE) err_inc = err_inc + 2'd1;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = bus.address;
                    wdata_d = bus.write_data;
                    both_d  = bus.read_en & bus.write_en;
                    state_d = (bus.read_en && !bus.write_en) ? READ : WRITE;
                end
            end
            WRITE: begin
                state_d = IDLE;
                if (!both_q && hit_ram) begin
                    mem_we = 1'b1;
                    wr_inc = 1'b1;
                end else if (!both_q && hit_periph && addr_q[3:2] == 2'd1) begin
                    scratch_d = wdata_q;
                    wr_inc    = 1'b1;
                end else begin
                    error_d = 1'b1;
                    err_inc = err_inc + 2'd1;
                end
            end
            READ: state_d = RESP;
            RESP: begin
                state_d      = IDLE;
                read_valid_d = 1'b1;
                if (hit_ram) begin
                    read_data_d = mem_q[addr_q[9:2]];
                end else if (hit_periph) begin
                    case (addr_q[3:2])
                        2'd0:    read_data_d = ID_VALUE;
                        2'd1:    read_data_d = scratch_q;
                        2'd2:    read_data_d = wr_cnt_q;
                        default: read_data_d = err_cnt_q;
                    endcase
                end else begin
                    error_d = 1'b1;
                    err_inc = err_inc + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_cnt_d  = wr_cnt_q + {31'd0, wr_inc};
        err_cnt_d = err_cnt_q + {30'd0, err_inc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= 16'd0;
            wdata_q      <= 32'd0;
            both_q       <= 1'b0;
            scratch_q    <= 32'd0;
            wr_cnt_q     <= 32'd0;
            err_cnt_q    <= 32'd0;
            read_data_q  <= 32'd0;
            read_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            both_q       <= both_d;
            scratch_q    <= scratch_d;
            wr_cnt_q     <= wr_cnt_d;
            err_cnt_q    <= err_cnt_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            error_q      <= error_d;
        end
    end

    // RAM has no reset; a reset edge still blocks an in-flight write.
    always_ff @(posedge clk) begin
        if (!reset && mem_we) mem_q[addr_q[9:2]] <= wdata_q;
    end

    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
    assign bus.error      = error_q;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 read_en  input  1  one-cycle read request strobe from the upstream processor.
REQ-005 write_en  input  1  one-cycle write request strobe.
REQ-006 address  input  16  byte address of the request.
REQ-007 write_data  input  32  write payload, sampled with write_en.
REQ-008 read_data  output  32  read response data, valid only while read_valid=1.
REQ-009 read_valid  output  1  one-cycle read completion pulse.
REQ-010 error  output  1  one-cycle fault pulse.
REQ-011 busy  output  1  high while a request is in flight; requests sampled while busy=1 are dropped.

Function
REQ-012 Address map SHALL be:
- RAM: 0x0000-0x03FF, 256x32 words, index address[9:2].
- Peripheral: 0x8000 ID (read-only, 32'hC0DE0003); 0x8004 SCRATCH (read/write, reset 0); 0x8008 WR_CNT (read-only); 0x800C ERR_CNT (read-only).
- Everything else is unmapped.
REQ-013 The FSM SHALL have four states: IDLE, WRITE, READ, RESP. Reset enters IDLE.
REQ-014 A request is accepted only in IDLE, at the edge E where read_en or write_en is sampled high. Address and data are latched at E.
REQ-015 Accepted write: state goes to WRITE at E. Storage is updated at E+1, busy=1 for one cycle, then IDLE.
REQ-016 Accepted read: state goes READ at E, then RESP at E+1. read_valid=1 and read_data are driven from edge E+2 for exactly one cycle. busy=1 from E to E+2. Return to IDLE at E+2.
REQ-017 Back-to-back requests spaced 2 cycles apart SHALL all be serviced. A write followed by a read to the same address SHALL return the new data.
REQ-018 A request sampled while busy=1 SHALL be dropped: no access, and ERR_CNT increments. error is not pulsed.
REQ-019 read_en and write_en high together SHALL perform no access. error pulses at E+1 and ERR_CNT increments.
REQ-020 A misaligned address (address[1:0]!=0) or an unmapped address SHALL perform no access and pulse error.
- Write: error at E+1.
- Read: read_valid and error both pulse at E+2, with read_data=0.
REQ-021 A write to ID, WR_CNT or ERR_CNT SHALL be ignored and SHALL pulse error at E+1.
REQ-022 WR_CNT SHALL increment by 1 on every successful RAM or SCRATCH write. ERR_CNT SHALL increment on every error pulse and on every dropped request. Both are 32-bit and wrap from 0xFFFFFFFF to 0.
REQ-023 read_data SHALL be 0 whenever read_valid=0.
REQ-024 RAM contents SHALL NOT be reset. A read of a never-written RAM word returns unspecified data.

Reset
REQ-025 While reset=1 at a clock edge, the following SHALL hold at that edge:
- read_data=0, read_valid=0, error=0, busy=0.
- SCRATCH=0, WR_CNT=0, ERR_CNT=0.
- FSM in IDLE.
REQ-026 Reset mid-operation SHALL abort the in-flight request: no RAM/SCRATCH update, no read_valid, no counter change.
REQ-027 Requests sampled at an edge where reset=1 SHALL be ignored.

Verification
REQ-028 Write then read: write 0x0004=0xDEADBEEF at edge E, read 0x0004 at E+2 -> read_valid with 0xDEADBEEF at E+4; WR_CNT=1.
REQ-029 Peripheral reads after reset: read 0x8000 -> 0xC0DE0003; read 0x8004 -> 0x00000000. Each read_valid arrives 2 edges after acceptance.
REQ-030 Errors: read 0x0006 -> read_valid+error with data 0; write 0x8000 -> error at E+1, ID unchanged; read_en+write_en together -> error, no access; read ERR_CNT -> 3.
REQ-031 Busy drop: read 0x0008 at E, write 0x0008 at E+1 -> write dropped, RAM unchanged, ERR_CNT=1, error never pulses.
REQ-032 Reset abort: write 0x000C=0x12345678, then write 0x000C=0xAAAAAAAA with reset=1 at E+1 -> subsequent read 0x000C returns 0x12345678; all outputs 0 after reset.
